tsp_city_loader: RTL

Serial input front end for the TSP solver: receives a city-list frame over a UART line (8N1), validates it, and writes each city's (x, y) coordinates into the solver's city memory. It is the inbound counterpart of the solver's result/display path, sitting between the board's RX pin and the city RAM write port inside `TSPTop_wrap`. It signals a completed load so the solver can start.

---
 rtl/tsp_city_loader.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/tsp_city_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tsp_city_loader
//  Purpose  : UART (8N1) front end for the TSP solver. It receives a framed
//             city list (0xA5, N, N x {x, y} [, checksum]), validates it and
//             writes each city's coordinates into the solver's city RAM.
//  Ports    : clk, rst      - system clock, asynchronous active-high reset
//             rx            - serial input, idle high, asynchronous to clk
//             wr_en         - one-cycle city RAM write strobe
//             wr_addr       - city index for the write
//             wr_x, wr_y    - coordinates for the write (held between writes)
//             num_cities    - city count of the last good frame
//             load_done     - one-cycle pulse, good frame completed
//             frame_err     - one-cycle pulse, frame aborted
//             busy          - high from header acceptance to frame end/abort
//  Config   : define TSP_LOADER_CHECKSUM_EN to require and check the trailing
//             XOR checksum byte; undefined, the frame ends after the last y.
//  Revision : 1.0 - initial release
// ============================================================================
module tsp_city_loader #(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 115200,
  parameter int MAX_CITIES   = 16,
  parameter int COORD_W      = 8,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic                          wr_en,
  output logic [$clog2(MAX_CITIES)-1:0] wr_addr,
  output logic [COORD_W-1:0]            wr_x,
  output logic [COORD_W-1:0]            wr_y,
  output logic [7:0]                    num_cities,
  output logic                          load_done,
  output logic                          frame_err,
  output logic                          busy
);

  localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int AW   = $clog2(MAX_CITIES);
  localparam int TOUT = TIMEOUT_BITS * DIV;
  localparam int TW   = $clog2(TOUT + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TOUT - 1);
  localparam logic [7:0]    MAX_N     = 8'(MAX_CITIES);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  // --------------------------------------------------------------------------
  // Input synchronizer; r_rx_prev gives the falling-edge reference.
  // --------------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rx_sync;
  logic r_rx_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // --------------------------------------------------------------------------
  // Byte receiver
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t      r_rx_state;
  logic [CW-1:0]  r_bit_cnt;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic           r_byte_valid;
  logic           r_stop_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state   <= RX_IDLE;
      r_bit_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_stop_err   <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_sync) begin
            r_rx_state <= RX_START;
            r_bit_cnt  <= '0;
          end
        end
        RX_START: begin
          if (r_bit_cnt == HALF_LAST) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            // Line back high at mid-start: a glitch, not a start bit.
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_bit_cnt <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_bit_cnt    <= '0;
            r_rx_state   <= RX_IDLE;
            r_byte_valid <= r_rx_sync;
            r_stop_err   <= !r_rx_sync;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM with registered outputs
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_COUNT = 3'd1,
    ST_X     = 3'd2,
    ST_Y     = 3'd3
`ifdef TSP_LOADER_CHECKSUM_EN
    ,
    ST_CSUM  = 3'd4
`endif
  } fsm_state_t;

  fsm_state_t    r_state;
  logic [7:0]    r_n;
  logic [7:0]    r_idx;
  logic [7:0]    r_x;
  logic [TW-1:0] r_timer;
`ifdef TSP_LOADER_CHECKSUM_EN
  logic [7:0]    r_csum;
`endif

  // The idle gap is measured from the last accepted byte; any receiver
  // activity (a start bit in progress) restarts it.
  logic w_rx_active;
  assign w_rx_active = (r_rx_state != RX_IDLE) || r_byte_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_HUNT;
      r_n        <= '0;
      r_idx      <= '0;
      r_x        <= '0;
      r_timer    <= '0;
`ifdef TSP_LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_x       <= '0;
      wr_y       <= '0;
      num_cities <= '0;
      load_done  <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      load_done <= 1'b0;
      frame_err <= 1'b0;

      if (r_state == ST_HUNT || w_rx_active) r_timer <= '0;
      else                                   r_timer <= r_timer + 1'b1;

      if (r_state != ST_HUNT && r_stop_err) begin
        frame_err <= 1'b1;
        busy      <= 1'b0;
        r_state   <= ST_HUNT;
      end else if (r_state != ST_HUNT && !w_rx_active && r_timer == TOUT_LAST) begin
        frame_err <= 1'b1;
        busy      <= 1'b0;
        r_state   <= ST_HUNT;
      end else if (r_byte_valid) begin
        case (r_state)
          ST_HUNT: begin
            if (r_shift == SYNC_BYTE) begin
              busy    <= 1'b1;
              r_state <= ST_COUNT;
            end
          end
          ST_COUNT: begin
            if (r_shift == 8'd0 || r_shift > MAX_N) begin
              frame_err <= 1'b1;
              busy      <= 1'b0;
              r_state   <= ST_HUNT;
            end else begin
              r_n     <= r_shift;
              r_idx   <= '0;
`ifdef TSP_LOADER_CHECKSUM_EN
              r_csum  <= r_shift;
`endif
              r_state <= ST_X;
            end
          end
          ST_X: begin
            r_x     <= r_shift;
`ifdef TSP_LOADER_CHECKSUM_EN
            r_csum  <= r_csum ^ r_shift;
`endif
            r_state <= ST_Y;
          end
          ST_Y: begin
            wr_en   <= 1'b1;
            wr_addr <= r_idx[AW-1:0];
            wr_x    <= COORD_W'(r_x);
            wr_y    <= COORD_W'(r_shift);
`ifdef TSP_LOADER_CHECKSUM_EN
            r_csum  <= r_csum ^ r_shift;
`endif
            if (r_idx == r_n - 8'd1) begin
`ifdef TSP_LOADER_CHECKSUM_EN
              r_state <= ST_CSUM;
`else
              // Without a checksum the frame completes with its last write.
              num_cities <= r_n;
              load_done  <= 1'b1;
              busy       <= 1'b0;
              r_state    <= ST_HUNT;
`endif
            end else begin
              r_idx   <= r_idx + 8'd1;
              r_state <= ST_X;
            end
          end
`ifdef TSP_LOADER_CHECKSUM_EN
          ST_CSUM: begin
            if (r_shift == r_csum) begin
              num_cities <= r_n;
              load_done  <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
            busy    <= 1'b0;
            r_state <= ST_HUNT;
          end
`endif
          default: begin
            busy    <= 1'b0;
            r_state <= ST_HUNT;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
